// File: rtl/core_pkg.sv
// Shared constants and types for the writeback controller slice.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int LD_DEPTH   = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // Which source drives the register-file write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE      = 2'd0,
    SRC_ALU       = 2'd1,
    SRC_LD_FIFO   = 2'd2,
    SRC_LD_BYPASS = 2'd3
  } wb_src_e;

endpackage : core_pkg

// File: rtl/core_wb_fifo.sv
// Power-of-two circular FIFO with head, full/empty flags and a view of every
// slot plus its occupancy mask, so callers can search the live contents.
module core_wb_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            din,
  output logic                        full,
  output logic                        empty,
  output logic [WIDTH-1:0]            head,
  output logic [DEPTH-1:0][WIDTH-1:0] entries,
  output logic [DEPTH-1:0]            valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign head    = mem[rd_ptr];
  // A pop frees a slot in the same cycle, so a push into a full FIFO is only
  // accepted alongside a pop; anything else would overwrite live data.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage write.
  // NOTE: the storage array has no reset; occupancy is tracked by cnt, so stale
  // slot contents are never observed and the array can map onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Expose every slot and mark it live when it lies within cnt of rd_ptr.
  always_comb begin
    logic [PTR_W-1:0] off;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off        = PTR_W'(i) - rd_ptr;
      entries[i] = mem[i];
      valid[i]   = (CNT_W'(off) < cnt);
    end
  end

endmodule : core_wb_fifo

// File: rtl/core_wb_ctrl.sv
// Writeback controller: owns the register-file write port, merges ALU results
// with in-order load responses, buffers loads that lose to the ALU, and stalls
// decode on RAW/WAW hazards against pending loads or the in-flight write.
module core_wb_ctrl #(
  parameter int XLEN     = core_pkg::XLEN,
  parameter int LD_DEPTH = core_pkg::LD_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_vld,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_req_vld,
  input  logic [4:0]      ld_req_rd,
  output logic            ld_req_rdy,
  input  logic            ld_rsp_vld,
  input  logic [XLEN-1:0] ld_rsp_data,
  input  logic            dec_vld,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic [4:0]      dec_rd,
  output logic            stall_out,
  output logic            we_out,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] data_out,
  output logic            ld_pending_out
);

  import core_pkg::*;

  // Tag FIFO: destinations of loads issued but not yet written back.
  logic                                 tag_push;
  logic                                 tag_pop;
  logic                                 tag_full;
  logic                                 tag_empty;
  reg_addr_t                            tag_head;
  logic [LD_DEPTH-1:0][REG_ADDR_W-1:0]  tag_entries;
  logic [LD_DEPTH-1:0]                  tag_valid;

  // Data FIFO: load responses that lost arbitration to the ALU.
  logic                                 data_push;
  logic                                 data_pop;
  logic                                 data_full;
  logic                                 data_empty;
  logic [XLEN-1:0]                      data_head;
  logic [LD_DEPTH-1:0][XLEN-1:0]        data_entries;
  logic [LD_DEPTH-1:0]                  data_valid;

  logic                                 rsp_ok;
  wb_src_e                              src;
  logic                                 sel_vld;
  reg_addr_t                            sel_rd;
  logic [XLEN-1:0]                      sel_data;
  logic [2:0][REG_ADDR_W-1:0]           dec_regs;
  logic                                 hazard;

  // Only the tag FIFO contents are searched; the data FIFO's view is not needed.
  logic                                 unused_data_view;
  assign unused_data_view = ^{data_entries, data_valid, data_full};

  assign ld_req_rdy     = !tag_full;
  assign ld_pending_out = !tag_empty;
  assign tag_push       = ld_req_vld && !tag_full;
  // A response with no outstanding tag has no destination and is dropped.
  assign rsp_ok         = ld_rsp_vld && !tag_empty;

  core_wb_fifo #(
    .WIDTH (REG_ADDR_W),
    .DEPTH (LD_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (tag_push),
    .pop     (tag_pop),
    .din     (ld_req_rd),
    .full    (tag_full),
    .empty   (tag_empty),
    .head    (tag_head),
    .entries (tag_entries),
    .valid   (tag_valid)
  );

  core_wb_fifo #(
    .WIDTH (XLEN),
    .DEPTH (LD_DEPTH)
  ) u_data_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (data_push),
    .pop     (data_pop),
    .din     (ld_rsp_data),
    .full    (data_full),
    .empty   (data_empty),
    .head    (data_head),
    .entries (data_entries),
    .valid   (data_valid)
  );

  // Arbitration: ALU has absolute priority; otherwise the oldest load data
  // (buffered first, then a live response bypassing an empty buffer).
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    src       = SRC_NONE;
    sel_rd    = REG_ZERO;
    sel_data  = '0;
    if (alu_vld) begin
      src      = SRC_ALU;
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end else if (!data_empty) begin
      src      = SRC_LD_FIFO;
      sel_rd   = tag_head;
      sel_data = data_head;
    end else if (rsp_ok) begin
      src      = SRC_LD_BYPASS;
      sel_rd   = tag_head;
      sel_data = ld_rsp_data;
    end
  end

  assign sel_vld   = (src != SRC_NONE);
  assign tag_pop   = (src == SRC_LD_FIFO) || (src == SRC_LD_BYPASS);
  assign data_pop  = (src == SRC_LD_FIFO);
  assign data_push = rsp_ok && (src != SRC_LD_BYPASS);

  // Output register: one cycle after selection; writes to x0 are suppressed.
  // NOTE: state is updated with non-blocking assignments so all flops sample
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_out   <= 1'b0;
      rd_out   <= REG_ZERO;
      data_out <= '0;
    end else if (sel_vld) begin
      we_out   <= (sel_rd != REG_ZERO);
      rd_out   <= sel_rd;
      data_out <= sel_data;
    end else begin
      we_out   <= 1'b0;
    end
  end

  assign dec_regs = {dec_rd, dec_rs2, dec_rs1};

  // Hazard search: any non-zero decode register matching a live load tag or
  // the write currently presented to the register file.
  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (dec_regs[s] != REG_ZERO) begin
        if (we_out && (dec_regs[s] == rd_out)) hazard = 1'b1;
        for (int i = 0; i < LD_DEPTH; i++) begin
          if (tag_valid[i] && (tag_entries[i] == dec_regs[s])) hazard = 1'b1;
        end
      end
    end
  end

  assign stall_out = dec_vld && hazard;

endmodule : core_wb_ctrl

// File: tb/tb_core_wb_ctrl.sv
// Scoreboard bench for core_wb_ctrl: a queue-based reference model predicts
// every register-file write and the per-cycle stall/ready/pending outputs.
module tb_core_wb_ctrl;

  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         alu_vld = 1'b0;
  logic [4:0]   alu_rd = '0;
  logic [W-1:0] alu_data = '0;
  logic         ld_req_vld = 1'b0;
  logic [4:0]   ld_req_rd = '0;
  logic         ld_req_rdy;
  logic         ld_rsp_vld = 1'b0;
  logic [W-1:0] ld_rsp_data = '0;
  logic         dec_vld = 1'b0;
  logic [4:0]   dec_rs1 = '0;
  logic [4:0]   dec_rs2 = '0;
  logic [4:0]   dec_rd = '0;
  logic         stall_out;
  logic         we_out;
  logic [4:0]   rd_out;
  logic [W-1:0] data_out;
  logic         ld_pending_out;

  core_wb_ctrl #(.XLEN(W), .LD_DEPTH(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_vld        (alu_vld),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .ld_req_vld     (ld_req_vld),
    .ld_req_rd      (ld_req_rd),
    .ld_req_rdy     (ld_req_rdy),
    .ld_rsp_vld     (ld_rsp_vld),
    .ld_rsp_data    (ld_rsp_data),
    .dec_vld        (dec_vld),
    .dec_rs1        (dec_rs1),
    .dec_rs2        (dec_rs2),
    .dec_rd         (dec_rd),
    .stall_out      (stall_out),
    .we_out         (we_out),
    .rd_out         (rd_out),
    .data_out       (data_out),
    .ld_pending_out (ld_pending_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]   rd;
    logic [W-1:0] data;
    int           cyc;
  } wb_t;

  // Reference model state: outstanding tags, buffered load data, last write.
  logic [4:0]   m_tags[$];
  logic [W-1:0] m_buf[$];
  bit           m_we = 1'b0;
  logic [4:0]   m_rd = '0;
  wb_t          sb[$];

  bit exp_stall = 1'b0;
  bit exp_rdy   = 1'b1;
  bit exp_pend  = 1'b0;
  bit chk_en    = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit haz(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (m_we && r == m_rd) return 1'b1;
    foreach (m_tags[i]) if (m_tags[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle of stimulus; the model predicts this cycle's combinational
  // outputs from its current state, then advances to the post-edge state.
  task automatic step(input bit a_v, input logic [4:0] a_rd, input logic [W-1:0] a_d,
                      input bit q_v, input logic [4:0] q_rd,
                      input bit r_v, input logic [W-1:0] r_d,
                      input bit d_v, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] dd);
    bit           rsp_ok;
    bit           req_ok;
    bit           sel;
    logic [4:0]   w_rd;
    logic [W-1:0] w_d;
    @(posedge clk);
    #1;
    alu_vld = a_v;  alu_rd = a_rd;  alu_data = a_d;
    ld_req_vld = q_v;  ld_req_rd = q_rd;
    ld_rsp_vld = r_v;  ld_rsp_data = r_d;
    dec_vld = d_v;  dec_rs1 = s1;  dec_rs2 = s2;  dec_rd = dd;

    exp_rdy   = (m_tags.size() < D);
    exp_pend  = (m_tags.size() != 0);
    exp_stall = d_v && (haz(s1) || haz(s2) || haz(dd));

    rsp_ok = r_v && (m_tags.size() != 0);
    req_ok = q_v && (m_tags.size() < D);
    sel  = 1'b0;
    w_rd = '0;
    w_d  = '0;
    if (a_v) begin
      sel = 1'b1;  w_rd = a_rd;  w_d = a_d;
      if (rsp_ok) m_buf.push_back(r_d);
    end else if (m_buf.size() > 0) begin
      sel  = 1'b1;
      w_rd = m_tags.pop_front();
      w_d  = m_buf.pop_front();
      if (rsp_ok) m_buf.push_back(r_d);
    end else if (rsp_ok) begin
      sel  = 1'b1;
      w_rd = m_tags.pop_front();
      w_d  = r_d;
    end
    if (req_ok) m_tags.push_back(q_rd);
    if (sel && w_rd != 5'd0) sb.push_back('{rd: w_rd, data: w_d, cyc: cyc + 1});
    m_we = sel && (w_rd != 5'd0);
    if (sel) m_rd = w_rd;
    chk_en = 1'b1;
  endtask

  task automatic idle(input bit d_v = 1'b0, input logic [4:0] s1 = '0,
                      input logic [4:0] dd = '0);
    step(0, '0, '0, 0, '0, 0, '0, d_v, s1, '0, dd);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    alu_vld = 1'b0;  ld_req_vld = 1'b0;  ld_rsp_vld = 1'b0;
    dec_vld = 1'b1;  dec_rs1 = 5'd7;  dec_rs2 = 5'd1;  dec_rd = 5'd2;
    m_tags.delete();
    m_buf.delete();
    sb.delete();
    m_we = 1'b0;
    m_rd = '0;
    #2;
    check("rst_we_out", we_out, 1'b0);
    check("rst_rd_out", rd_out, 5'd0);
    check("rst_data_out", data_out, '0);
    check("rst_ld_req_rdy", ld_req_rdy, 1'b1);
    check("rst_stall_out", stall_out, 1'b0);
    check("rst_ld_pending", ld_pending_out, 1'b0);
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: each falling edge, compare the write port against the scoreboard
  // head and the combinational outputs against this cycle's prediction.
  always @(negedge clk) begin : monitor
    bit  due;
    wb_t e;
    if (chk_en) begin
      due = (sb.size() > 0) && (sb[0].cyc <= cyc);
      check("we_out", we_out, due);
      if (due) begin
        e = sb.pop_front();
        if (we_out) begin
          check("rd_out", rd_out, e.rd);
          check("data_out", data_out, e.data);
        end
      end
      check("stall_out", stall_out, exp_stall);
      check("ld_req_rdy", ld_req_rdy, exp_rdy);
      check("ld_pending_out", ld_pending_out, exp_pend);
    end
  end

  initial begin
    do_reset(2);

    // ALU write, then idle.
    step(1, 5'd5, 32'h1234, 0, '0, 0, '0, 0, '0, '0, '0);
    idle();
    idle();

    // Load bypass with RAW stall on rs1=7 lasting through the write cycle.
    step(0, '0, '0, 1, 5'd7, 0, '0, 1, 5'd7, '0, '0);
    idle(1, 5'd7);
    idle(1, 5'd7);
    step(0, '0, '0, 0, '0, 1, 32'hDEADBEEF, 1, 5'd7, '0, '0);
    idle(1, 5'd7);
    idle(1, 5'd7);
    idle(1, 5'd7);

    // Collision: ALU wins, buffered load written the following cycle.
    step(0, '0, '0, 1, 5'd3, 0, '0, 0, '0, '0, '0);
    idle();
    step(1, 5'd4, 32'hBB, 0, '0, 1, 32'hAA, 0, '0, '0, '0);
    idle();
    idle();

    // Fill the tag FIFO, try a fifth load, then drain in order.
    for (int i = 1; i <= 4; i++) step(0, '0, '0, 1, 5'(i), 0, '0, 0, '0, '0, '0);
    step(0, '0, '0, 1, 5'd9, 0, '0, 1, 5'd9, '0, '0);
    for (int i = 1; i <= 4; i++) step(0, '0, '0, 0, '0, 1, 32'h100 + i, 0, '0, '0, '0);
    idle();
    idle();

    // x0 load, then WAW stall on dec_rd and no stall on x0 sources.
    step(0, '0, '0, 1, 5'd0, 0, '0, 0, '0, '0, '0);
    step(0, '0, '0, 0, '0, 1, 32'hCAFE, 1, 5'd0, '0, '0);
    idle();
    step(0, '0, '0, 1, 5'd9, 0, '0, 0, '0, '0, '0);
    idle(1, 5'd0, 5'd9);
    idle(1, 5'd0, 5'd0);
    step(0, '0, '0, 0, '0, 1, 32'h99, 0, '0, '0, '0);
    idle();
    idle();

    // Reset with loads pending, then a late response that must be dropped.
    step(0, '0, '0, 1, 5'd11, 0, '0, 0, '0, '0, '0);
    step(0, '0, '0, 1, 5'd12, 0, '0, 0, '0, '0, '0);
    do_reset(1);
    step(0, '0, '0, 0, '0, 1, 32'h5555, 1, 5'd11, 5'd12, '0);
    idle();
    idle();

    // Randomized traffic honoring the response protocol.
    for (int n = 0; n < 3000; n++) begin
      bit r_v;
      if (n == 1500) do_reset(2);
      if (m_tags.size() > m_buf.size()) r_v = ($urandom_range(0, 1) == 1);
      else                              r_v = (m_tags.size() == 0) && ($urandom_range(0, 15) == 0);
      step($urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
           r_v, $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    // Drain with a bounded budget.
    for (int n = 0; n < 200 && (m_tags.size() > 0 || sb.size() > 0); n++)
      step(0, '0, '0, 0, '0, m_tags.size() > m_buf.size(), $urandom, 0, '0, '0, '0);
    idle();
    idle();
    @(posedge clk);
    #1;
    check("drain_pending", ld_pending_out, 1'b0);
    check("drain_scoreboard", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_core_wb_ctrl
